// File: rtl/fp_norm_round_pack.sv
`default_nettype none
// ============================================================================
// Module      : fp_norm_round_pack
// Description : Back end of the FP add/sub datapath. Normalizes a 48-bit
//               mantissa sum a few positions per cycle, rounds it in the
//               selected RISC-V rounding mode and packs a binary32 result
//               together with its exception flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_norm_round_pack #(
  parameter int SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic [47:0] mant_in,
  input  logic        nan_in,
  input  logic        invalid_in,
  input  logic        inf_in,
  input  logic        zero_in,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  fflags
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] c_RM_RTZ = 3'd1;
  localparam logic [2:0] c_RM_RDN = 3'd2;
  localparam logic [2:0] c_RM_RUP = 3'd3;
  localparam logic [2:0] c_RM_RMM = 3'd4;
  localparam logic [9:0] c_STEP   = 10'(SHIFT_STEP);

  state_t       r_state,  w_state_nxt;
  logic         r_sign,   w_sign_nxt;
  logic [2:0]   r_rm,     w_rm_nxt;
  logic [9:0]   r_e,      w_e_nxt;
  logic [46:0]  r_mant,   w_mant_nxt;
  logic         r_sticky, w_sticky_nxt;
  logic [31:0]  r_result, w_result_nxt;
  logic [4:0]   r_fflags, w_fflags_nxt;

  // Accept-time pre-processing: clamp subnormal exponent, absorb carry bit
  logic [9:0]   w_acc_e;
  logic [46:0]  w_acc_mant;
  logic         w_acc_sticky;

  // Normalization step
  logic [5:0]   w_lz;
  logic [9:0]   w_room;
  logic [9:0]   w_need;
  logic [9:0]   w_k;
  logic         w_norm_done;

  // Rounding
  logic         w_g;
  logic         w_s;
  logic         w_nx;
  logic         w_tiny;
  logic         w_up;
  logic [24:0]  w_sum;
  logic [23:0]  w_sig;
  logic [9:0]   w_e_rnd;
  logic         w_ovf;
  logic         w_to_inf;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign fflags    = r_fflags;

  // Exponent clamp and carry fold-in applied to the incoming bundle
  always_comb begin
    w_acc_e      = ((exp_in == 8'd0) ? 10'd1 : {2'b00, exp_in}) + {9'b0, mant_in[47]};
    w_acc_mant   = mant_in[47] ? mant_in[47:1] : mant_in[46:0];
    w_acc_sticky = mant_in[47] & mant_in[0];
  end

  // Leading-zero count from bit46 and the bounded shift for this cycle
  always_comb begin
    w_lz = 6'd47;
    for (int i = 0; i < 47; i++) begin
      if (r_mant[i]) w_lz = 6'(46 - i);
    end
    w_room      = r_e - 10'd1;
    w_need      = ({4'b0, w_lz} < w_room) ? {4'b0, w_lz} : w_room;
    w_k         = (w_need > c_STEP) ? c_STEP : w_need;
    w_norm_done = (w_need == w_k);
  end

  // Round-increment decision, significand carry and overflow detection
  always_comb begin
    w_g    = r_mant[22];
    w_s    = (|r_mant[21:0]) | r_sticky;
    w_nx   = w_g | w_s;
    w_tiny = ~r_mant[46];
    case (r_rm)
      c_RM_RTZ: w_up = 1'b0;
      c_RM_RDN: w_up = r_sign & w_nx;
      c_RM_RUP: w_up = ~r_sign & w_nx;
      c_RM_RMM: w_up = w_g;
      default:  w_up = w_g & (w_s | r_mant[23]);
    endcase
    w_sum    = {1'b0, r_mant[46:23]} + 25'(w_up);
    w_sig    = w_sum[24] ? 24'h800000 : w_sum[23:0];
    w_e_rnd  = r_e + {9'b0, w_sum[24]};
    w_ovf    = (w_e_rnd >= 10'd255);
    // Saturate to max finite only when the mode rounds toward zero magnitude
    w_to_inf = ~((r_rm == c_RM_RTZ) ||
                 ((r_rm == c_RM_RUP) && r_sign) ||
                 ((r_rm == c_RM_RDN) && !r_sign));
  end

  // Next-state and datapath register updates for every state
  always_comb begin
    w_state_nxt  = r_state;
    w_sign_nxt   = r_sign;
    w_rm_nxt     = r_rm;
    w_e_nxt      = r_e;
    w_mant_nxt   = r_mant;
    w_sticky_nxt = r_sticky;
    w_result_nxt = r_result;
    w_fflags_nxt = r_fflags;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_sign_nxt   = sign_in;
          w_rm_nxt     = rm;
          w_e_nxt      = w_acc_e;
          w_mant_nxt   = w_acc_mant;
          w_sticky_nxt = w_acc_sticky;
          w_fflags_nxt = 5'b0;
          if (nan_in) begin
            w_result_nxt = 32'h7FC00000;
            w_fflags_nxt = {invalid_in, 4'b0};
            w_state_nxt  = S_DONE;
          end else if (inf_in) begin
            w_result_nxt = {sign_in, 8'hFF, 23'b0};
            w_state_nxt  = S_DONE;
          end else if (zero_in || (w_acc_mant == 47'd0)) begin
            w_result_nxt = {(rm == c_RM_RDN), 31'b0};
            w_state_nxt  = S_DONE;
          end else begin
            w_state_nxt  = S_NORM;
          end
        end
      end
      S_NORM: begin
        w_mant_nxt = r_mant << w_k;
        w_e_nxt    = r_e - w_k;
        if (w_norm_done) w_state_nxt = S_ROUND;
      end
      S_ROUND: begin
        if (w_ovf) begin
          w_result_nxt = w_to_inf ? {r_sign, 8'hFF, 23'b0} : {r_sign, 8'hFE, 23'h7FFFFF};
          w_fflags_nxt = 5'b00101;
        end else begin
          w_result_nxt = {r_sign, (w_sig[23] ? w_e_rnd[7:0] : 8'h00), w_sig[22:0]};
          w_fflags_nxt = {3'b000, w_tiny & w_nx, w_nx};
        end
        w_state_nxt = S_DONE;
      end
      default: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_sign   <= 1'b0;
      r_rm     <= 3'd0;
      r_e      <= 10'd0;
      r_mant   <= 47'd0;
      r_sticky <= 1'b0;
      r_result <= 32'd0;
      r_fflags <= 5'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_sign   <= w_sign_nxt;
      r_rm     <= w_rm_nxt;
      r_e      <= w_e_nxt;
      r_mant   <= w_mant_nxt;
      r_sticky <= w_sticky_nxt;
      r_result <= w_result_nxt;
      r_fflags <= w_fflags_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_norm_round_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_norm_round_pack
// Description : Directed-vector scoreboard bench for fp_norm_round_pack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_norm_round_pack;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [47:0] mant_in;
  logic        nan_in;
  logic        invalid_in;
  logic        inf_in;
  logic        zero_in;
  logic [2:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  fflags;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_done   = 0;
  int   neg_cnt  = 0;
  int   acc_neg  = 0;
  bit   lat_armed = 0;
  bit   track     = 1;

  fp_norm_round_pack #(.SHIFT_STEP(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in), .nan_in(nan_in),
    .invalid_in(invalid_in), .inf_in(inf_in), .zero_in(zero_in), .rm(rm),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .fflags(fflags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  // Monitor: measures latency from accept and pops expectations on handshake
  always @(negedge clk) begin
    exp_t e;
    neg_cnt++;
    if (!reset_n) begin
      lat_armed = 0;
    end else begin
      if (in_valid && in_ready && track) begin
        acc_neg   = neg_cnt;
        lat_armed = 1;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          if (lat_armed) begin
            chk("latency", 32'(neg_cnt - acc_neg), 32'(exp_q[0].lat));
            lat_armed = 0;
          end
          if (out_ready) begin
            e = exp_q.pop_front();
            chk("result", result, e.res);
            chk("fflags", 32'(fflags), 32'(e.flg));
            n_done++;
          end
        end
      end
    end
  end

  task automatic drive(input logic s, input logic [7:0] e, input logic [47:0] m,
                       input logic nan, input logic inv, input logic inf,
                       input logic zer, input logic [2:0] r);
    sign_in = s; exp_in = e; mant_in = m; nan_in = nan; invalid_in = inv;
    inf_in = inf; zero_in = zer; rm = r; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (n_done == d0 && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    if (n_done == d0) begin
      chk("timeout", 32'(n_done), 32'(d0 + 1));
      exp_q.delete();
    end
  endtask

  task automatic send(input logic s, input logic [7:0] e, input logic [47:0] m,
                      input logic nan, input logic inv, input logic inf,
                      input logic zer, input logic [2:0] r,
                      input logic [31:0] er, input logic [4:0] ef, input int el);
    exp_t x;
    int   d0;
    x.res = er; x.flg = ef; x.lat = el;
    exp_q.push_back(x);
    d0 = n_done;
    drive(s, e, m, nan, inv, inf, zer, r);
    wait_done(d0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   d0;
    int   t;
    exp_t x;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sign_in = 1'b0;
    exp_in = 8'd0; mant_in = 48'd0; nan_in = 1'b0; invalid_in = 1'b0;
    inf_in = 1'b0; zero_in = 1'b0; rm = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_fflags", 32'(fflags), 32'd0);
    #1 reset_n = 1'b1;
    @(posedge clk); #2;

    //   s  exp     mant              nan inv inf zer rm    result        flags     lat
    send(0, 8'd127, 48'h8000_0000_0000, 0, 0, 0, 0, 3'd0, 32'h40000000, 5'b00000, 3);
    send(0, 8'd127, 48'h0000_0080_0000, 0, 0, 0, 0, 3'd0, 32'h34000000, 5'b00000, 5);
    send(0, 8'd0,   48'h2000_0000_0000, 0, 0, 0, 0, 3'd0, 32'h00400000, 5'b00000, 3);
    send(0, 8'd127, 48'h4000_0040_0000, 0, 0, 0, 0, 3'd0, 32'h3F800000, 5'b00001, 3);
    send(0, 8'd127, 48'h4000_00C0_0000, 0, 0, 0, 0, 3'd0, 32'h3F800002, 5'b00001, 3);
    send(0, 8'd127, 48'h4000_00C0_0000, 0, 0, 0, 0, 3'd1, 32'h3F800001, 5'b00001, 3);
    send(0, 8'd127, 48'h4000_00C0_0000, 0, 0, 0, 0, 3'd7, 32'h3F800002, 5'b00001, 3);
    send(1, 8'd127, 48'h4000_0040_0000, 0, 0, 0, 0, 3'd2, 32'hBF800001, 5'b00001, 3);
    send(0, 8'd127, 48'h4000_0040_0000, 0, 0, 0, 0, 3'd4, 32'h3F800001, 5'b00001, 3);
    send(0, 8'd127, 48'h4000_0000_0001, 0, 0, 0, 0, 3'd3, 32'h3F800001, 5'b00001, 3);
    send(0, 8'd0,   48'h3FFF_FFC0_0000, 0, 0, 0, 0, 3'd0, 32'h00800000, 5'b00011, 3);
    send(0, 8'd5,   48'h0000_0000_0001, 0, 0, 0, 0, 3'd0, 32'h00000000, 5'b00011, 3);
    send(0, 8'd254, 48'h8000_0000_0000, 0, 0, 0, 0, 3'd0, 32'h7F800000, 5'b00101, 3);
    send(0, 8'd254, 48'h8000_0000_0000, 0, 0, 0, 0, 3'd1, 32'h7F7FFFFF, 5'b00101, 3);
    send(1, 8'd254, 48'h8000_0000_0000, 0, 0, 0, 0, 3'd3, 32'hFF7FFFFF, 5'b00101, 3);
    send(0, 8'd100, 48'h0000_0000_0000, 0, 0, 0, 0, 3'd2, 32'h80000000, 5'b00000, 1);
    send(0, 8'd0,   48'h0000_0000_0000, 0, 0, 0, 1, 3'd2, 32'h80000000, 5'b00000, 1);
    send(0, 8'd0,   48'h0000_0000_0000, 0, 0, 0, 1, 3'd0, 32'h00000000, 5'b00000, 1);
    send(0, 8'd0,   48'h0000_0000_0000, 1, 1, 1, 1, 3'd0, 32'h7FC00000, 5'b10000, 1);
    send(1, 8'd0,   48'h0000_0000_0000, 0, 0, 1, 1, 3'd0, 32'hFF800000, 5'b00000, 1);

    // Backpressure: result must hold and no new accept while stalled
    out_ready = 1'b0;
    x.res = 32'h40000000; x.flg = 5'b00000; x.lat = 3;
    exp_q.push_back(x);
    d0 = n_done;
    drive(0, 8'd127, 48'h8000_0000_0000, 0, 0, 0, 0, 3'd0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("stall_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_result", result, 32'h40000000);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_done(d0);

    // Reset mid-NORM: the in-flight operation is dropped
    track = 0;
    drive(0, 8'd127, 48'h0000_0080_0000, 0, 0, 0, 0, 3'd0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_result", result, 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    track = 1;
    @(posedge clk); #2;
    send(0, 8'd127, 48'h0000_0080_0000, 0, 0, 0, 0, 3'd0, 32'h34000000, 5'b00000, 5);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_norm_round_pack.md
Name: fp_norm_round_pack

Overview:
- Back end of the FP add/sub datapath: consumes the sign, common exponent and 48-bit mantissa sum from the extract/align + adder stages.
- Normalizes the sum iteratively, rounds per the RISC-V rounding mode, and packs an IEEE-754 binary32 result with fflags.
- Multi-cycle, valid/ready on both sides, so the F-unit can share one normalizer across add/sub ops.

Parameters:
- SHIFT_STEP, 8, maximum left-shift positions per NORM cycle (1..47)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block can accept a bundle
- sign_in  in  1  result sign
- exp_in  in  8  common biased exponent; 0 = subnormal scale (effective exponent 1)
- mant_in  in  48  sum; bit47 = carry, bit46 = hidden-bit position, bits45:23 = fraction, bits22:0 = extra
- nan_in  in  1  result is NaN
- invalid_in  in  1  raise NV (sNaN operand or inf-inf)
- inf_in  in  1  result is infinity with sign_in
- zero_in  in  1  exact cancellation
- rm  in  3  rounding mode: RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4; 5-7 treated as RNE
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  packed binary32
- fflags  out  5  {NV,DZ,OF,UF,NX}; DZ always 0

Behaviour:
- Reset (async, reset_n=0): state IDLE; in_ready=1, out_valid=0, result=0, fflags=0, all internal registers cleared. Takes effect immediately, including mid-operation; the in-flight op is dropped.
- States: IDLE, NORM, ROUND, DONE. in_ready=1 only in IDLE. Accept = in_valid && in_ready. All inputs (including rm) are latched at accept.
- Accept with nan_in/inf_in/zero_in set: go to DONE; out_valid asserted the cycle after accept. Priority is nan > inf > zero.
  - NaN: result 0x7FC00000; NV = invalid_in.
  - Inf: result {sign_in, 0xFF, 0}.
  - Zero: result {rm==RDN, 31'b0}.
  - All other flags 0.
- Normal accept:
  - e = max(exp_in,1), held in a 10-bit internal register.
  - If mant_in[47]=1: mant = mant_in>>1, sticky = mant_in[0], e = e+1. Otherwise mant = mant_in, sticky = 0.
  - mant==0 goes to DONE with +0 (−0 if RDN).
  - Otherwise go to NORM.
- NORM:
  - lz = leading zeros counting down from bit46.
  - Each cycle shift left by k = min(SHIFT_STEP, lz, e−1); e −= k.
  - Go to ROUND in the same cycle the remaining shift is 0 after this step, i.e. mant[46]=1 or e==1.
  - NORM occupies max(1, ceil(total_shift/SHIFT_STEP)) cycles.
- ROUND (1 cycle):
  - lsb = mant[23], g = mant[22], s = |mant[21:0] | sticky.
  - Round-up condition per mode:
    - RNE: g&(s|lsb)
    - RTZ: 0
    - RDN: sign&(g|s)
    - RUP: !sign&(g|s)
    - RMM: g
  - Add 1 to 24-bit mant[46:23]. On carry-out the significand becomes 1.0 and e+1.
  - Exponent field: e if significand bit23=1, else 0 (subnormal). A subnormal rounding into bit23 naturally yields field 1.
  - NX = g|s. UF = tiny&NX, where tiny means mant[46]=0 before rounding.
  - Overflow (e≥255 after rounding):
    - OF=NX=1.
    - Result is inf for RNE/RMM, for RUP when +, and for RDN when −.
    - Otherwise result is max finite {sign,0xFE,0x7FFFFF}.
  - Go to DONE.
- DONE: out_valid=1; result and fflags held stable until out_ready=1, then go to IDLE (out_valid=0 next cycle). No new accept while in DONE.
- Latency: out_valid rises 1 (accept) + NORM cycles + 1 (ROUND) cycles after the accept edge. Minimum is 3 for normal ops, 1 for specials.
- result/fflags are registered and change only when entering DONE.

Test Plan:
1. 1.0+1.0: exp_in=127, mant_in=48'h8000_0000_0000, RNE -> result 0x40000000, fflags 0, out_valid 3 cycles after accept.
2. Cancellation: exp_in=127, mant_in=48'h0000_0080_0000, SHIFT_STEP=8 -> 3 NORM cycles, result 0x34000000, fflags 0, out_valid at cycle 5. Subnormal case: exp_in=0, mant_in=48'h2000_0000_0000 -> 0x00400000, UF=0.
3. Ties: exp_in=127, mant_in=48'h4000_0040_0000 RNE -> 0x3F800000, NX=1. mant_in=48'h4000_00C0_0000 -> 0x3F800002, NX=1. Same input under RTZ -> 0x3F800001.
4. Overflow: exp_in=254, mant_in=48'h8000_0000_0000.
   - RNE -> 0x7F800000, fflags 5'b00101.
   - RTZ -> 0x7F7FFFFF, fflags 5'b00101.
   - sign_in=1, RUP -> 0xFF7FFFFF.
5. Specials:
   - zero_in with RDN -> 0x80000000; with RNE -> 0x00000000.
   - nan_in+invalid_in -> 0x7FC00000, fflags 5'b10000.
   - inf_in, sign_in=1 -> 0xFF800000.
   - Each gives out_valid 1 cycle after accept.
6. Backpressure/reset:
   - out_ready=0 for 5 cycles -> result stable, in_ready=0.
   - reset_n pulsed low mid-NORM -> out_valid=0 and in_ready=1 immediately; next op completes correctly.
